// File: rtl/bell_pkg.sv
// Shared types and nominal tone periods for the doorbell link (transmit and receive sides).
// Latency: none; this package holds only declarations and a pure helper function.
// Backpressure: none.
package bell_pkg;

    typedef enum logic [1:0] {
        TONE_NONE = 2'b00,
        TONE_1    = 2'b01,
        TONE_2    = 2'b10
    } tone_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        QUAL   = 2'b01,
        LOCKED = 2'b10
    } state_e;

    // Nominal full periods in clk cycles; the bell transmitter uses the same values.
    localparam int BELL_TONE1_PERIOD = 100;
    localparam int BELL_TONE2_PERIOD = 150;

    // True when per lies within nom-tol .. nom+tol, both ends inclusive.
    function automatic logic in_window(input int per, input int nom, input int tol);
        return (per >= nom - tol) && (per <= nom + tol);
    endfunction

endpackage

// File: rtl/bell_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone input, plus rising-edge detect.
// Latency: rise is high between the 2nd and 3rd clk edges after d rises; the 3rd edge consumes it.
// Backpressure: none; rise is a single-cycle strobe.
// Ports: clk, rst (sync, active-high), d (async tone), rise (combinational strobe).
module bell_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s;
    logic s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= d;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/bell_tone_decoder.sv
// Measures the bell tone period, classifies it, qualifies over MATCH_N periods, reports press events.
// Latency: start_pls/end_pls register on the 3rd clk edge after the deciding tone_in rising edge.
// Backpressure: none; events are 1-cycle pulses that downstream must sample.
// Ports: clk, rst (sync, active-high), tone_in (async), present, tone_id[1:0],
//        start_pls, end_pls, press_cnt[7:0] (locks since reset, wrapping).
module bell_tone_decoder
    import bell_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int TONE1_PERIOD = BELL_TONE1_PERIOD,
    parameter int TONE2_PERIOD = BELL_TONE2_PERIOD,
    parameter int TOL          = 4,
    parameter int MATCH_N      = 4,
    parameter int SILENCE      = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic       present,
    output logic [1:0] tone_id,
    output logic       start_pls,
    output logic       end_pls,
    output logic [7:0] press_cnt
);

    localparam int              MW      = $clog2(MATCH_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SIL_CNT = CNT_W'(SILENCE);
    localparam logic [MW-1:0]    MATCH_T = MW'(MATCH_N);

    logic rise;

    bell_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (tone_in),
        .rise (rise)
    );

    // Cycles since the last rise; at a rise it holds the just-finished period.
    logic [CNT_W-1:0] per_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
        end else if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_W'(1);
        end
    end

    tone_e cls;

    always_comb begin
        cls = TONE_NONE;
        if (in_window(32'(per_cnt), TONE1_PERIOD, TOL)) begin
            cls = TONE_1;
        end else if (in_window(32'(per_cnt), TONE2_PERIOD, TOL)) begin
            cls = TONE_2;
        end
    end

    state_e        state, state_n;
    tone_e         cand, cand_n;
    logic [MW-1:0] match, match_n;
    logic          lock_ev;
    logic          end_ev;

    // While LOCKED, cand holds the locked tone.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        match_n = match;
        lock_ev = 1'b0;
        end_ev  = 1'b0;
        case (state)
            IDLE: begin
                // First edge after silence only starts the period timer.
                if (rise) begin
                    state_n = QUAL;
                    cand_n  = TONE_NONE;
                    match_n = '0;
                end
            end
            QUAL: begin
                if (rise) begin
                    if (cls != TONE_NONE && cls == cand) begin
                        match_n = match + MW'(1);
                    end else begin
                        cand_n  = cls;
                        match_n = (cls != TONE_NONE) ? MW'(1) : '0;
                    end
                    if (match_n >= MATCH_T) begin
                        state_n = LOCKED;
                        lock_ev = 1'b1;
                    end
                end else if (per_cnt == SIL_CNT) begin
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (cls != cand) begin
                        end_ev  = 1'b1;
                        state_n = QUAL;
                        cand_n  = cls;
                        match_n = (cls != TONE_NONE) ? MW'(1) : '0;
                    end
                end else if (per_cnt == SIL_CNT) begin
                    end_ev  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // tone_id keeps the ended tone during the end_pls cycle and clears on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= TONE_NONE;
            match     <= '0;
            present   <= 1'b0;
            tone_id   <= TONE_NONE;
            start_pls <= 1'b0;
            end_pls   <= 1'b0;
            press_cnt <= '0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            match     <= match_n;
            start_pls <= lock_ev;
            end_pls   <= end_ev;
            if (lock_ev) begin
                present   <= 1'b1;
                tone_id   <= cand_n;
                press_cnt <= press_cnt + 8'd1;
            end else if (end_ev) begin
                present <= 1'b0;
            end else if (!present) begin
                tone_id <= TONE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_bell_tone_decoder.sv
module tb_bell_tone_decoder;

    logic clk = 1'b0;
    always #1 clk = ~clk;

    logic       rst    = 1'b1;
    logic       tone_a = 1'b0;
    logic       tone_b = 1'b0;
    logic       present_a, start_a, end_a;
    logic [1:0] tone_id_a;
    logic [7:0] press_a;
    logic       present_b, start_b, end_b;
    logic [1:0] tone_id_b;
    logic [7:0] press_b;

    // Default-parameter instance: the nominal doorbell tones.
    bell_tone_decoder u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone_a),
        .present   (present_a),
        .tone_id   (tone_id_a),
        .start_pls (start_a),
        .end_pls   (end_a),
        .press_cnt (press_a)
    );

    // Short periods so 256 locks fit in a few thousand cycles.
    bell_tone_decoder #(
        .TONE1_PERIOD (8),
        .TONE2_PERIOD (12),
        .TOL          (1),
        .MATCH_N      (2),
        .SILENCE      (30)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone_b),
        .present   (present_b),
        .tone_id   (tone_id_b),
        .start_pls (start_b),
        .end_pls   (end_b),
        .press_cnt (press_b)
    );

    // Reference model: rising edges are timestamped by clk edge index, periods are
    // timestamp differences, and qualification is a run length of equal classes.
    typedef struct packed {
        int         t1;
        int         t2;
        int         tol;
        int         mn;
        int         sil;
        int         k;
        int         last;
        int         cand;
        int         run;
        int         locked;
        int         ended;
        int         presses;
        logic [2:0] hist;     // tone samples at edges k-1, k-2, k-3
        logic       active;
        logic       e_start;
        logic       e_end;
    } mdl_t;

    mdl_t ma, mb;
    int   compared   = 0;
    int   mismatched = 0;
    int   n_start_a  = 0;
    int   n_end_a    = 0;
    int   end_id_a   = 0;

    function automatic int classify(mdl_t m, int per);
        int d1, d2;
        d1 = per - m.t1;
        if (d1 < 0) d1 = -d1;
        d2 = per - m.t2;
        if (d2 < 0) d2 = -d2;
        if (d1 <= m.tol) return 1;
        if (d2 <= m.tol) return 2;
        return 0;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic tin, logic r);
        mdl_t n;
        logic edge_seen;
        int   per, cls;
        n         = m;
        n.k       = m.k + 1;
        n.e_start = 1'b0;
        n.e_end   = 1'b0;
        if (r) begin
            n.hist    = 3'b000;
            n.active  = 1'b0;
            n.locked  = 0;
            n.presses = 0;
            n.cand    = 0;
            n.run     = 0;
            n.last    = n.k;
        end else begin
            // An input rising edge is acted on at the third clk edge that follows it.
            edge_seen = m.hist[1] && !m.hist[2];
            n.hist    = {m.hist[1:0], tin};
            if (edge_seen) begin
                per    = n.k - m.last;
                n.last = n.k;
                cls    = classify(m, per);
                if (!m.active) begin
                    n.active = 1'b1;
                    n.cand   = 0;
                    n.run    = 0;
                end else if (m.locked != 0) begin
                    if (cls != m.locked) begin
                        n.e_end  = 1'b1;
                        n.ended  = m.locked;
                        n.locked = 0;
                        n.cand   = cls;
                        n.run    = (cls != 0) ? 1 : 0;
                    end
                end else begin
                    if (cls != 0 && cls == m.cand) begin
                        n.run = m.run + 1;
                    end else begin
                        n.cand = cls;
                        n.run  = (cls != 0) ? 1 : 0;
                    end
                    if (n.run >= m.mn) begin
                        n.locked  = n.cand;
                        n.e_start = 1'b1;
                        n.presses = (m.presses + 1) % 256;
                    end
                end
            end else if (m.active && (n.k - m.last == m.sil)) begin
                if (m.locked != 0) begin
                    n.e_end = 1'b1;
                    n.ended = m.locked;
                end
                n.locked = 0;
                n.active = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic [12:0] expv(mdl_t m);
        logic [1:0] id;
        id = (m.locked != 0) ? 2'(m.locked) : (m.e_end ? 2'(m.ended) : 2'b00);
        return {m.locked != 0, id, m.e_start, m.e_end, 8'(m.presses)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s differs from expectation", tag);
        end
    endtask

    // One clk cycle: drive at the falling edge, model the rising edge, sample at the next falling edge.
    task automatic step(input logic ta, input logic tb);
        tone_a = ta;
        tone_b = tb;
        @(posedge clk);
        ma = mstep(ma, ta, rst);
        mb = mstep(mb, tb, rst);
        @(negedge clk);
        chk("cycle_a", {19'd0, present_a, tone_id_a, start_a, end_a, press_a}, {19'd0, expv(ma)});
        chk("cycle_b", {19'd0, present_b, tone_id_b, start_b, end_b, press_b}, {19'd0, expv(mb)});
        if (start_a === 1'b1) n_start_a++;
        if (end_a === 1'b1) begin
            n_end_a++;
            end_id_a = int'(tone_id_a);
        end
    endtask

    task automatic wave_a(input int per, input int n, input logic rnd);
        int hi;
        for (int i = 0; i < n; i++) begin
            hi = rnd ? int'($urandom_range(per - 1, 1)) : per / 2;
            for (int c = 0; c < per; c++) step(c < hi, 1'b0);
        end
    endtask

    task automatic wave_b(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < per; c++) step(1'b0, c < per / 2);
        end
    endtask

    initial begin
        int s0, e0, st, endj, base;

        ma = '0; ma.t1 = 100; ma.t2 = 150; ma.tol = 4; ma.mn = 4; ma.sil = 400;
        mb = '0; mb.t1 = 8;   mb.t2 = 12;  mb.tol = 1; mb.mn = 2; mb.sil = 30;
        @(negedge clk);

        // Reset with the tone toggling.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(i[0], i[0]);
        chk("reset_outputs", {19'd0, present_a, tone_id_a, start_a, end_a, press_a}, 32'd0);
        rst = 1'b0;

        // Period 100: lock on the 5th input rising edge, seen 3 clk edges later.
        st = -1;
        for (int i = 0; i < 1000; i++) begin
            step((i % 100) < 50, 1'b0);
            if (start_a === 1'b1 && st < 0) st = i;
        end
        chk("t1_start_cycle", st, 402);
        chk("t1_start_count", n_start_a, 1);
        chk("t1_id", tone_id_a, 1);
        chk("t1_press", press_a, 1);

        // Switch to period 150.
        s0 = n_start_a; e0 = n_end_a;
        wave_a(150, 6, 1'b1);
        chk("sw_end_count", n_end_a - e0, 1);
        chk("sw_end_id", end_id_a, 1);
        chk("sw_start_count", n_start_a - s0, 1);
        chk("sw_id", tone_id_a, 2);
        chk("sw_press", press_a, 2);

        // Period 110 is outside both windows.
        s0 = n_start_a; e0 = n_end_a;
        wave_a(110, 8, 1'b1);
        chk("p110_no_start", n_start_a - s0, 0);
        chk("p110_end_id", end_id_a, 2);
        chk("p110_present", present_a, 0);

        // Periods at both window edges lock TONE1; 95 is just outside.
        s0 = n_start_a;
        for (int i = 0; i < 6; i++) wave_a((i % 2 == 1) ? 104 : 96, 1, 1'b1);
        chk("edge_lock", n_start_a - s0, 1);
        chk("edge_id", tone_id_a, 1);
        e0 = n_end_a;
        wave_a(95, 3, 1'b1);
        chk("p95_end", n_end_a - e0, 1);
        chk("p95_end_id", end_id_a, 1);

        // Lock TONE2, then silence: the end pulse lands 400 cycles after the last edge was seen.
        wave_a(150, 6, 1'b1);
        chk("t2_present", present_a, 1);
        endj = -1;
        for (int j = 1; j <= 450; j++) begin
            step(1'b0, 1'b0);
            if (end_a === 1'b1 && endj < 0) endj = j;
        end
        chk("silence_end_cycle", endj, 253);
        chk("silence_present", present_a, 0);
        wave_a(150, 4, 1'b1);
        chk("relock_4_edges", present_a, 0);
        wave_a(150, 1, 1'b1);
        chk("relock_5_edges", present_a, 1);

        // Jittered groups around both nominal periods.
        for (int g = 0; g < 8; g++) begin
            base = ($urandom_range(1, 0) == 1) ? 100 : 150;
            for (int p = 0; p < 5; p++) wave_a(base + int'($urandom_range(12, 0)) - 6, 1, 1'b1);
        end

        // Reset while locked.
        wave_a(100, 7, 1'b1);
        chk("pre_rst_present", present_a, 1);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_locked", {19'd0, present_a, tone_id_a, start_a, end_a, press_a}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // press_cnt wrap on the short-period instance.
        wave_b(8, 1);
        for (int i = 0; i < 256; i++) begin
            wave_b(3, 1);
            wave_b(8, 2);
        end
        chk("press_255", press_b, 255);
        wave_b(3, 1);
        chk("press_wrap", press_b, 0);
        chk("wrap_present", present_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
